// File: rtl/compare_unit_if.sv
// Request/response bundle for the compare unit: valid/ready request side
// carrying operands, op and tag; valid/ready response side carrying the
// selected result, raw integer flags, FP invalid flag and the returned tag.
interface compare_unit_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;

    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic             eq;
    logic             lt_u;
    logic             lt_s;
    logic             fflag_nv;
    logic             illegal_op;
    logic [TAG_W-1:0] out_tag;

    // Requester / result consumer side.
    modport master (
        output in_valid, a, b, op, tag, out_ready,
        input  in_ready, out_valid, result, eq, lt_u, lt_s,
               fflag_nv, illegal_op, out_tag
    );

    // Compare unit side.
    modport slave (
        input  in_valid, a, b, op, tag, out_ready,
        output in_ready, out_valid, result, eq, lt_u, lt_s,
               fflag_nv, illegal_op, out_tag
    );
endinterface

// File: rtl/compare_unit.sv
// Two-stage pipelined compare unit. Stage 1 computes the integer
// subtract-based flags, the FP operand classes and the magnitude ordering;
// stage 2 selects the per-op result and invalid flag into the output
// registers. Both stages freeze while the consumer holds off a result.
module compare_unit #(
    parameter int WIDTH = 64,
    parameter int EXP_W = 11,
    parameter int TAG_W = 5
) (
    input logic            clk,
    input logic            reset,
    compare_unit_if.slave  bus
);
    localparam int MANT_W = WIDTH - 1 - EXP_W;

    typedef enum logic [2:0] {
        OP_EQ   = 3'b000,
        OP_LT   = 3'b001,
        OP_LTU  = 3'b010,
        OP_FEQ  = 3'b011,
        OP_FLT  = 3'b100,
        OP_FLE  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    typedef struct packed {
        logic nan;
        logic snan;
        logic zero;
        logic sign;
    } fclass_t;

    function automatic fclass_t classify(input logic [WIDTH-1:0] x);
        fclass_t c;
        logic    exp_ones;
        logic    mant_nz;
        exp_ones = &x[WIDTH-2 -: EXP_W];
        mant_nz  = |x[MANT_W-1:0];
        c.nan    = exp_ones & mant_nz;
        c.snan   = exp_ones & mant_nz & ~x[MANT_W-1];
        c.zero   = ~|x[WIDTH-2:0];
        c.sign   = x[WIDTH-1];
        return c;
    endfunction

    // Handshake: a held-off result freezes the whole pipe.
    logic stall;
    logic advance;
    logic accept;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign advance      = ~stall;
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    // A - B as A + ~B + 1; carry-out clear means A < B unsigned.
    logic [WIDTH:0] diff;
    logic           d_eq;
    logic           d_lt_u;
    logic           d_lt_s;
    logic           d_mag_lt;
    logic           d_mag_eq;

    assign diff     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign d_eq     = (diff[WIDTH-1:0] == '0);
    assign d_lt_u   = ~diff[WIDTH];
    // Differing signs decide directly, so signed overflow of S never matters.
    assign d_lt_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) ? bus.a[WIDTH-1]
                                                          : diff[WIDTH-1];
    assign d_mag_lt = (bus.a[WIDTH-2:0] <  bus.b[WIDTH-2:0]);
    assign d_mag_eq = (bus.a[WIDTH-2:0] == bus.b[WIDTH-2:0]);

    // Stage 1 registers.
    logic             s1_valid;
    logic             s1_eq;
    logic             s1_lt_u;
    logic             s1_lt_s;
    logic             s1_mag_lt;
    logic             s1_mag_eq;
    fclass_t          s1_a_cls;
    fclass_t          s1_b_cls;
    op_e              s1_op;
    logic [TAG_W-1:0] s1_tag;

    // Stage 1 occupancy: loads the request valid whenever the pipe moves.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
        end
    end

    // Stage 1 payload: captured only on an accepted request.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; s1_valid alone gates their
        // use, so resetting them would only add fan-out on the reset net.
        if (accept) begin
            s1_eq     <= d_eq;
            s1_lt_u   <= d_lt_u;
            s1_lt_s   <= d_lt_s;
            s1_mag_lt <= d_mag_lt;
            s1_mag_eq <= d_mag_eq;
            s1_a_cls  <= classify(bus.a);
            s1_b_cls  <= classify(bus.b);
            s1_op     <= op_e'(bus.op);
            s1_tag    <= bus.tag;
        end
    end

    // Stage 2 selection logic.
    logic both_zero;
    logic any_nan;
    logic any_snan;
    logic f_eq;
    logic f_lt;
    logic res_d;
    logic nv_d;
    logic ill_d;

    // FP ordering in sign-magnitude form, then per-op result/flag selection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        f_lt      = 1'b0;
        res_d     = 1'b0;
        nv_d      = 1'b0;
        ill_d     = 1'b0;
        both_zero = s1_a_cls.zero & s1_b_cls.zero;
        any_nan   = s1_a_cls.nan | s1_b_cls.nan;
        any_snan  = s1_a_cls.snan | s1_b_cls.snan;
        f_eq      = both_zero | ((s1_a_cls.sign == s1_b_cls.sign) & s1_mag_eq);

        if (both_zero) begin
            f_lt = 1'b0;
        end else if (s1_a_cls.sign != s1_b_cls.sign) begin
            f_lt = s1_a_cls.sign;
        end else if (s1_a_cls.sign) begin
            // Both negative: larger magnitude is the smaller value.
            f_lt = ~s1_mag_lt & ~s1_mag_eq;
        end else begin
            f_lt = s1_mag_lt;
        end

        case (s1_op)
            OP_EQ:   res_d = s1_eq;
            OP_LT:   res_d = s1_lt_s;
            OP_LTU:  res_d = s1_lt_u;
            OP_FEQ: begin
                res_d = ~any_nan & f_eq;
                nv_d  = any_snan;
            end
            OP_FLT: begin
                res_d = ~any_nan & f_lt;
                nv_d  = any_nan;
            end
            OP_FLE: begin
                res_d = ~any_nan & (f_lt | f_eq);
                nv_d  = any_nan;
            end
            default: ill_d = 1'b1;
        endcase
    end

    // Output registers.
    logic             out_valid_q;
    logic             result_q;
    logic             eq_q;
    logic             lt_u_q;
    logic             lt_s_q;
    logic             nv_q;
    logic             ill_q;
    logic [TAG_W-1:0] tag_q;

    // Stage 2: moves stage 1 into the outputs; bubbles clear out_valid only.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            eq_q        <= 1'b0;
            lt_u_q      <= 1'b0;
            lt_s_q      <= 1'b0;
            nv_q        <= 1'b0;
            ill_q       <= 1'b0;
            tag_q       <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q <= res_d;
                eq_q     <= s1_eq;
                lt_u_q   <= s1_lt_u;
                lt_s_q   <= s1_lt_s;
                nv_q     <= nv_d;
                ill_q    <= ill_d;
                tag_q    <= s1_tag;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.eq         = eq_q;
    assign bus.lt_u       = lt_u_q;
    assign bus.lt_s       = lt_s_q;
    assign bus.fflag_nv   = nv_q;
    assign bus.illegal_op = ill_q;
    assign bus.out_tag    = tag_q;
endmodule

// File: tb/tb_compare_unit.sv
// Self-checking bench for compare_unit (WIDTH=64). Requests are queued,
// the expected response is pushed to a scoreboard when the DUT accepts a
// request and popped/compared when the DUT hands a result over.
module tb_compare_unit;
    localparam int WIDTH = 64;
    localparam int EXP_W = 11;
    localparam int TAG_W = 5;

    localparam logic [63:0] P_ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] P_TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] N_ONE  = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] N_TWO  = 64'hC000_0000_0000_0000;
    localparam logic [63:0] N_ZERO = 64'h8000_0000_0000_0000;
    localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] SNAN   = 64'h7FF0_0000_0000_0001;
    localparam logic [63:0] P_INF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] MIN_I  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX_I  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [2:0]       op;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic             result;
        logic             eq;
        logic             lt_u;
        logic             lt_s;
        logic             nv;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    req_t req_q[$];
    rsp_t sb_q[$];

    compare_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    compare_unit #(.WIDTH(WIDTH), .EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer operators and real-valued FP ordering.
    function automatic rsp_t model(input req_t r);
        rsp_t m;
        real  ra;
        real  rb;
        logic an;
        logic bn;
        logic asn;
        logic bsn;
        m        = '0;
        m.tag    = r.tag;
        m.eq     = (r.a == r.b);
        m.lt_u   = (r.a < r.b);
        m.lt_s   = ($signed(r.a) < $signed(r.b));
        an       = (r.a[62:52] == 11'h7FF) && (r.a[51:0] != 0);
        bn       = (r.b[62:52] == 11'h7FF) && (r.b[51:0] != 0);
        asn      = an && !r.a[51];
        bsn      = bn && !r.b[51];
        ra       = $bitstoreal(r.a);
        rb       = $bitstoreal(r.b);
        case (r.op)
            3'b000: m.result = m.eq;
            3'b001: m.result = m.lt_s;
            3'b010: m.result = m.lt_u;
            3'b011: begin
                m.result = !(an || bn) && (ra == rb);
                m.nv     = asn || bsn;
            end
            3'b100: begin
                m.result = !(an || bn) && (ra < rb);
                m.nv     = an || bn;
            end
            3'b101: begin
                m.result = !(an || bn) && (ra <= rb);
                m.nv     = an || bn;
            end
            default: m.ill = 1'b1;
        endcase
        return m;
    endfunction

    task automatic push_req(input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [TAG_W-1:0] tag);
        req_t r;
        r.op  = op;
        r.a   = a;
        r.b   = b;
        r.tag = tag;
        req_q.push_back(r);
    endtask

    function automatic rsp_t observe();
        rsp_t o;
        o.result = bus.result;
        o.eq     = bus.eq;
        o.lt_u   = bus.lt_u;
        o.lt_s   = bus.lt_s;
        o.nv     = bus.fflag_nv;
        o.ill    = bus.illegal_op;
        o.tag    = bus.out_tag;
        return o;
    endfunction

    // Streams every queued request back-to-back; out_ready is low during
    // cycles [low_from, low_from+low_len). Runs until all results are seen.
    task automatic run_queue(input string name, input int low_from, input int low_len,
                             output int first_out, output int cycles, output int stalls);
        int   want;
        int   got;
        logic prev_stall;
        rsp_t snap;
        rsp_t obs;
        rsp_t exp;
        want       = req_q.size();
        got        = 0;
        cycles     = 0;
        stalls     = 0;
        first_out  = -1;
        prev_stall = 1'b0;
        snap       = '0;
        while (got < want && cycles < 200) begin
            if (req_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.op       = req_q[0].op;
                bus.a        = req_q[0].a;
                bus.b        = req_q[0].b;
                bus.tag      = req_q[0].tag;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = !(cycles >= low_from && cycles < low_from + low_len);
            @(negedge clk);
            obs = observe();
            n_checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                n_fail++;
                $display("FAIL %s in_ready cyc %0d: got %b out_valid %b out_ready %b",
                         name, cycles, bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (prev_stall) begin
                n_checks++;
                if (obs !== snap || bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s hold cyc %0d: got %h expected %h",
                             name, cycles, obs, snap);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                snap       = obs;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.in_valid && bus.in_ready)
                sb_q.push_back(model(req_q.pop_front()));
            if (bus.out_valid && bus.out_ready) begin
                if (first_out < 0) first_out = cycles;
                got++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected result %h", name, obs);
                end else begin
                    exp = sb_q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL %s rsp tag %0d: got %h expected %h",
                                 name, exp.tag, obs, exp);
                    end
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d results expected %0d", name, got, want);
        end
        req_q.delete();
        sb_q.delete();
    endtask

    task automatic test_reset();
        int fo, cy, st;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'b001;
        bus.a         = ALL1;
        bus.b         = 64'd1;
        bus.tag       = 5'd7;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (observe() !== rsp_t'(0)) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected 0", observe());
        end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        push_req(3'b001, ALL1, 64'd1, 5'd1);
        run_queue("reset_lt", 999, 0, fo, cy, st);
        n_checks++;
        if (fo != 2) begin
            n_fail++;
            $display("FAIL reset latency: got %0d expected 2", fo);
        end
    endtask

    task automatic test_int_sweep();
        int fo, cy, st;
        push_req(3'b000, 64'd5, 64'd5, 5'd2);
        push_req(3'b010, 64'd0, ALL1,  5'd3);
        push_req(3'b001, MIN_I, 64'd0, 5'd4);
        push_req(3'b001, MAX_I, MIN_I, 5'd5);
        push_req(3'b000, 64'd0, 64'd0, 5'd6);
        push_req(3'b010, MIN_I, 64'd0, 5'd7);
        push_req(3'b001, 64'd3, 64'd3, 5'd8);
        run_queue("int_sweep", 999, 0, fo, cy, st);
    endtask

    task automatic test_back_to_back();
        int fo, cy, st;
        for (int i = 0; i < 4; i++)
            push_req(3'($urandom_range(0, 2)), {$urandom, $urandom},
                     {$urandom, $urandom}, 5'(16 + i));
        run_queue("back_to_back", 999, 0, fo, cy, st);
        n_checks++;
        if (cy != 6) begin
            n_fail++;
            $display("FAIL back_to_back cycles: got %0d expected 6", cy);
        end
    endtask

    task automatic test_fp();
        int fo, cy, st;
        push_req(3'b011, 64'd0, N_ZERO, 5'd9);
        push_req(3'b100, P_ONE, P_TWO,  5'd10);
        push_req(3'b101, N_TWO, N_TWO,  5'd11);
        push_req(3'b100, N_ONE, N_TWO,  5'd12);
        push_req(3'b100, N_ZERO, 64'd0, 5'd13);
        push_req(3'b101, P_INF, P_TWO,  5'd14);
        push_req(3'b100, N_ONE, P_ONE,  5'd15);
        run_queue("fp", 999, 0, fo, cy, st);
    endtask

    task automatic test_nan();
        int fo, cy, st;
        push_req(3'b011, QNAN, P_ONE, 5'd20);
        push_req(3'b011, SNAN, P_ONE, 5'd21);
        push_req(3'b101, QNAN, QNAN,  5'd22);
        push_req(3'b100, P_ONE, SNAN, 5'd23);
        run_queue("nan", 999, 0, fo, cy, st);
    endtask

    task automatic test_backpressure();
        int fo, cy, st;
        for (int i = 0; i < 5; i++)
            push_req(3'($urandom_range(0, 5)), {$urandom, $urandom},
                     {$urandom, $urandom}, 5'(24 + i));
        run_queue("backpressure", 3, 3, fo, cy, st);
        n_checks++;
        if (st != 3) begin
            n_fail++;
            $display("FAIL backpressure stall cycles: got %0d expected 3", st);
        end
    endtask

    task automatic test_illegal();
        int fo, cy, st;
        push_req(3'b111, 64'd4, 64'd9, 5'd29);
        push_req(3'b110, 64'd9, 64'd9, 5'd30);
        push_req(3'b010, 64'd1, 64'd2, 5'd31);
        run_queue("illegal", 999, 0, fo, cy, st);

        // Two ops in flight, then reset: nothing may emerge afterwards.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'b000;
        bus.a         = 64'd1;
        bus.b         = 64'd1;
        bus.tag       = 5'd3;
        @(posedge clk);
        #1;
        bus.tag = 5'd4;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight out_valid: got %b expected 1", bus.out_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset out_valid cyc %0d: got %b expected 0",
                         i, bus.out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_int_sweep();
        test_back_to_back();
        test_fp();
        test_nan();
        test_backpressure();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
